vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_hv_counter.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing generator.
//   - byte offsets of the device-bus registers (address bits [4:2] decoded)
//   - bit positions inside CTRL
//   - ctrl_t, the packed view of the CTRL register (bit 0 = en)
package vga_pkg;

  localparam logic [4:0] VGA_CTRL   = 5'h00;
  localparam logic [4:0] VGA_FG     = 5'h04;
  localparam logic [4:0] VGA_BG     = 5'h08;
  localparam logic [4:0] VGA_STATUS = 5'h0C;
  localparam logic [4:0] VGA_IRQCLR = 5'h10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_SRC     = 2;
  localparam int CTRL_PATTERN = 3;

  typedef struct packed {
    logic pattern;
    logic src;
    logic irq_en;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/vga_hv_counter.sv
// vga_hv_counter: pixel-clock divider plus horizontal/vertical position counters.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           counting enable (CTRL.en as registered)
//   clr          synchronous clear request, wins over counting
//   tick         one-clock pulse per pixel (only while en)
//   x, y         current pixel position
//   frame_start  tick at position (0,0)
module vga_hv_counter #(
  parameter int unsigned CntW   = 11,
  parameter int unsigned PixDiv = 2,
  parameter int unsigned HT     = 800,
  parameter int unsigned VT     = 525
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  output logic            tick,
  output logic [CntW-1:0] x,
  output logic [CntW-1:0] y,
  output logic            frame_start
);

  localparam int unsigned DivW = (PixDiv > 1) ? $clog2(PixDiv) : 1;
  localparam logic [DivW-1:0] DIV_LAST = DivW'(PixDiv - 1);
  localparam logic [CntW-1:0] X_LAST   = CntW'(HT - 1);
  localparam logic [CntW-1:0] Y_LAST   = CntW'(VT - 1);

  logic [DivW-1:0] div_q;

  // With PixDiv == 1 the divider sits at 0 == DIV_LAST, so tick fires every cycle.
  assign tick        = en && (div_q == DIV_LAST);
  assign frame_start = tick && (x == '0) && (y == '0);

  // Disabled (or being disabled this cycle) parks everything at 0 so that
  // re-enabling always restarts a frame from the top-left corner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      x     <= '0;
      y     <= '0;
    end else if (!en || clr) begin
      div_q <= '0;
      x     <= '0;
      y     <= '0;
    end else if (tick) begin
      div_q <= '0;
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/colour generator on the device bus.
// Ports:
//   clk_i, rst_ni                 system clock, asynchronous active-low reset
//   device_req_i/addr/we/be/wdata bus request (addr bits [4:2] select a register)
//   device_rvalid_o/rdata_o       response one clock after any request
//   pix_rgb_i                     streamed pixel used when CTRL.src=1
//   hsync_o, vsync_o, rgb_o       registered VGA outputs (1-clock latency, aligned)
//   hcount_o, vcount_o            current x/y (unregistered)
//   pix_tick_o                    one-clock pulse per pixel
//   frame_irq_o                   sticky frame-start interrupt, gated by CTRL.irq_en
// Build option: define VGA_TEST_PATTERN_EN to build the 8-bar test pattern
// selected by CTRL[3]; without it CTRL[3] is read-only zero.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CD        = 12,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntW      = 11,
  parameter int unsigned PixDiv    = 2,
  parameter int unsigned HD        = 640,
  parameter int unsigned HF        = 16,
  parameter int unsigned HR        = 96,
  parameter int unsigned HB        = 48,
  parameter int unsigned VD        = 480,
  parameter int unsigned VF        = 10,
  parameter int unsigned VR        = 2,
  parameter int unsigned VB        = 33,
  parameter bit          HsPol     = 1'b0,
  parameter bit          VsPol     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic [CD-1:0]        pix_rgb_i,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic [CD-1:0]        rgb_o,
  output logic [CntW-1:0]      hcount_o,
  output logic [CntW-1:0]      vcount_o,
  output logic                 pix_tick_o,
  output logic                 frame_irq_o
);

  localparam int unsigned HT = HD + HF + HR + HB;
  localparam int unsigned VT = VD + VF + VR + VB;

  localparam logic [CntW-1:0] HS_START = CntW'(HD + HF);
  localparam logic [CntW-1:0] HS_END   = CntW'(HD + HF + HR);
  localparam logic [CntW-1:0] VS_START = CntW'(VD + VF);
  localparam logic [CntW-1:0] VS_END   = CntW'(VD + VF + VR);
  localparam logic [CntW-1:0] H_DISP   = CntW'(HD);
  localparam logic [CntW-1:0] V_DISP   = CntW'(VD);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [3:0] CTRL_WMASK = 4'b1111;
`else
  localparam logic [3:0] CTRL_WMASK = 4'b0111;
`endif

  if (HT >= 2 ** CntW) begin : g_bad_ht
    $error("vga_timing_gen: HT does not fit in CntW bits");
  end
  if (VT >= 2 ** CntW) begin : g_bad_vt
    $error("vga_timing_gen: VT does not fit in CntW bits");
  end
  if (PixDiv == 0) begin : g_bad_div
    $error("vga_timing_gen: PixDiv must be at least 1");
  end
  if (CD > DataWidth) begin : g_bad_cd
    $error("vga_timing_gen: CD must not exceed DataWidth");
  end

  ctrl_t             ctrl_q, ctrl_d;
  logic [CD-1:0]     fg_q, bg_q;
  logic [15:0]       frames_q;
  logic              irq_pend_q;
  logic [4:0]        offset;
  logic              wr_en;
  logic              irq_clr;
  logic [DataWidth-1:0] be_mask;
  logic [3:0]        ctrl_m;
  logic [DataWidth-1:0] rdata_d;
  logic              tick, frame_start;
  logic [CntW-1:0]   x, y;
  logic              hs_active, vs_active, video_on, vblank;
  logic [CD-1:0]     pix_d;
  logic              unused_ok;

  assign offset  = {device_addr_i[4:2], 2'b00};
  assign wr_en   = device_req_i && device_we_i;
  assign be_mask = DataWidth'({{8{device_be_i[3]}}, {8{device_be_i[2]}},
                               {8{device_be_i[1]}}, {8{device_be_i[0]}}});
  assign ctrl_m  = be_mask[3:0] & CTRL_WMASK;
  assign irq_clr = wr_en && (offset == VGA_IRQCLR) && device_be_i[0] && device_wdata_i[0];

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en && offset == VGA_CTRL) begin
      ctrl_d = ctrl_t'((ctrl_q & ~ctrl_m) | (device_wdata_i[3:0] & ctrl_m));
    end
  end

  // The clear uses the value being written so the counters drop to 0 on the
  // same edge that clears CTRL.en, not one clock later.
  vga_hv_counter #(
    .CntW  (CntW),
    .PixDiv(PixDiv),
    .HT    (HT),
    .VT    (VT)
  ) u_hv_counter (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .en         (ctrl_q.en),
    .clr        (!ctrl_d.en),
    .tick       (tick),
    .x          (x),
    .y          (y),
    .frame_start(frame_start)
  );

  assign hcount_o    = x;
  assign vcount_o    = y;
  assign pix_tick_o  = tick;
  assign frame_irq_o = irq_pend_q && ctrl_q.irq_en;

  assign hs_active = (x >= HS_START) && (x < HS_END);
  assign vs_active = (y >= VS_START) && (y < VS_END);
  assign video_on  = (x < H_DISP) && (y < V_DISP);
  assign vblank    = (y >= V_DISP);

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned XW = CntW + 3;
  logic [2:0]    bar_idx;
  logic [CD-1:0] bar_rgb;

  // Bar index = x*8/HD, done as compares against constant boundaries k*HD.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({x, 3'b000} >= XW'(k * HD)) bar_idx = 3'(k);
    end
  end

  assign bar_rgb = CD'({{(CD/3){bar_idx[2]}}, {(CD/3){bar_idx[1]}}, {(CD/3){bar_idx[0]}}});
`endif

  always_comb begin
    pix_d = bg_q;
    if (video_on) pix_d = ctrl_q.src ? pix_rgb_i : fg_q;
`ifdef VGA_TEST_PATTERN_EN
    if (video_on && ctrl_q.pattern) pix_d = bar_rgb;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_o <= ~HsPol;
      vsync_o <= ~VsPol;
      rgb_o   <= '0;
    end else begin
      hsync_o <= hs_active ? HsPol : ~HsPol;
      vsync_o <= vs_active ? VsPol : ~VsPol;
      rgb_o   <= pix_d;
    end
  end

  // Set beats clear when a frame starts in the same cycle as an IRQCLR write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      frames_q   <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      if (wr_en && offset == VGA_FG)
        fg_q <= (fg_q & ~be_mask[CD-1:0]) | (device_wdata_i[CD-1:0] & be_mask[CD-1:0]);
      if (wr_en && offset == VGA_BG)
        bg_q <= (bg_q & ~be_mask[CD-1:0]) | (device_wdata_i[CD-1:0] & be_mask[CD-1:0]);
      if (frame_start) begin
        frames_q   <= frames_q + 16'd1;
        irq_pend_q <= 1'b1;
      end else if (irq_clr) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    case (offset)
      VGA_CTRL:   rdata_d = DataWidth'(ctrl_q);
      VGA_FG:     rdata_d = DataWidth'(fg_q);
      VGA_BG:     rdata_d = DataWidth'(bg_q);
      VGA_STATUS: rdata_d = DataWidth'({vblank, irq_pend_q, frames_q});
      default:    rdata_d = '0;
    endcase
  end

  // Read data is held between requests; write responses carry zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      if (device_req_i) device_rdata_o <= device_we_i ? '0 : rdata_d;
    end
  end

  assign unused_ok = ^{device_addr_i, device_wdata_i, be_mask, ctrl_q};

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with a small timing set
// (HT=14, VT=7, PixDiv=2). Stimulus pushes expected bus responses and
// cycle-tagged video expectations; two monitors pop and compare them.
module tb_vga_timing_gen;

  localparam int CD = 12;
  localparam int HT_TB = 14;
  localparam int VT_TB = 7;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            device_req_i;
  logic [31:0]     device_addr_i;
  logic            device_we_i;
  logic [3:0]      device_be_i;
  logic [31:0]     device_wdata_i;
  logic            device_rvalid_o;
  logic [31:0]     device_rdata_o;
  logic [CD-1:0]   pix_rgb_i;
  logic            hsync_o, vsync_o;
  logic [CD-1:0]   rgb_o;
  logic [10:0]     hcount_o, vcount_o;
  logic            pix_tick_o, frame_irq_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int e_cyc;

  typedef struct {
    int cyc;
    int kind;
    logic [31:0] val;
  } vexp_t;

  typedef struct {
    int issue;
    bit chk;
    logic [31:0] data;
  } bexp_t;

  vexp_t vq[$];
  bexp_t bq[$];

  vga_timing_gen #(
    .CD(12), .AddrWidth(32), .DataWidth(32), .CntW(11), .PixDiv(2),
    .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1),
    .HsPol(1'b0), .VsPol(1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .pix_rgb_i      (pix_rgb_i),
    .hsync_o        (hsync_o),
    .vsync_o        (vsync_o),
    .rgb_o          (rgb_o),
    .hcount_o       (hcount_o),
    .vcount_o       (vcount_o),
    .pix_tick_o     (pix_tick_o),
    .frame_irq_o    (frame_irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic string kindName(input int k);
    case (k)
      0: return "hcount";
      1: return "vcount";
      2: return "pix_tick";
      3: return "hsync";
      4: return "vsync";
      5: return "rgb";
      default: return "frame_irq";
    endcase
  endfunction

  function automatic logic [31:0] kindActual(input int k);
    case (k)
      0: return 32'(hcount_o);
      1: return 32'(vcount_o);
      2: return 32'(pix_tick_o);
      3: return 32'(hsync_o);
      4: return 32'(vsync_o);
      5: return 32'(rgb_o);
      default: return 32'(frame_irq_o);
    endcase
  endfunction

  // Video monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    vexp_t e;
    while (vq.size() > 0 && vq[0].cyc <= cyc) begin
      e = vq.pop_front();
      if (e.cyc < cyc) checkOutput({kindName(e.kind), "_missed"}, 32'(cyc), 32'(e.cyc));
      else checkOutput(kindName(e.kind), kindActual(e.kind), e.val);
    end
  end

  // Bus monitor: every response must arrive exactly one clock after its request.
  always @(negedge clk) begin
    bexp_t b;
    if (rst_ni && device_rvalid_o) begin
      if (bq.size() == 0) begin
        checkOutput("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        b = bq.pop_front();
        checkOutput("rvalid_latency", 32'(cyc - b.issue), 32'd1);
        if (b.chk) checkOutput("rdata", device_rdata_o, b.data);
      end
    end
  end

  function automatic int posX(input int s);
    return (s / 2) % HT_TB;
  endfunction

  function automatic int posY(input int s);
    return ((s / 2) / HT_TB) % VT_TB;
  endfunction

  task automatic pushV(input int c, input int k, input logic [31:0] v);
    vq.push_back('{c, k, v});
  endtask

  // Expected video for cycles e+first..e+last, where e is the first cycle with en=1.
  task automatic pushFrame(input int e, input int first, input int last,
                           input logic [31:0] vis, input logic [31:0] bg);
    int px, py;
    for (int s = first; s <= last; s++) begin
      px = posX(s - 1);
      py = posY(s - 1);
      pushV(e + s, 0, 32'(posX(s)));
      pushV(e + s, 1, 32'(posY(s)));
      pushV(e + s, 2, 32'(s % 2));
      pushV(e + s, 3, (px >= 10 && px < 12) ? 32'd0 : 32'd1);
      pushV(e + s, 4, (py == 5) ? 32'd0 : 32'd1);
      pushV(e + s, 5, (px < 8 && py < 4) ? vis : bg);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input bit chk, input logic [31:0] exp);
    bq.push_back('{cyc, chk, exp});
    device_req_i   = 1'b1;
    device_we_i    = we;
    device_addr_i  = addr;
    device_be_i    = be;
    device_wdata_i = wdata;
    @(negedge clk);
    device_req_i = 1'b0;
    device_we_i  = 1'b0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    applyStimulus(1'b1, addr, be, wdata, 1'b0, 32'd0);
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, addr, 4'hF, 32'd0, 1'b1, exp);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((vq.size() > 0 || bq.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (vq.size() > 0 || bq.size() > 0) begin
      checkOutput("drain_timeout", 32'(vq.size() + bq.size()), 32'd0);
      vq.delete();
      bq.delete();
    end
  endtask

  task automatic resetDut();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hsync"}, 32'(hsync_o), 32'd1);
    checkOutput({tag, "_vsync"}, 32'(vsync_o), 32'd1);
    checkOutput({tag, "_rgb"}, 32'(rgb_o), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(device_rvalid_o), 32'd0);
    checkOutput({tag, "_rdata"}, device_rdata_o, 32'd0);
    checkOutput({tag, "_irq"}, 32'(frame_irq_o), 32'd0);
    checkOutput({tag, "_hcount"}, 32'(hcount_o), 32'd0);
    checkOutput({tag, "_vcount"}, 32'(vcount_o), 32'd0);
    checkOutput({tag, "_tick"}, 32'(pix_tick_o), 32'd0);
  endtask

  initial begin
    rst_ni         = 1'b0;
    device_req_i   = 1'b0;
    device_addr_i  = '0;
    device_we_i    = 1'b0;
    device_be_i    = '0;
    device_wdata_i = '0;
    pix_rgb_i      = '0;
    @(negedge clk);
    resetDut();
    checkResetState("reset");

    // Register reset values, then colours and free-running timing for a full frame.
    $display("[TB] phase 1: timing and register colour");
    busRead(32'h00, 32'h0);
    busRead(32'h04, 32'h0);
    busRead(32'h08, 32'h0);
    busRead(32'h0C, 32'h0);
    busWrite(32'h04, 4'hF, 32'h0000_0F00);
    busWrite(32'h08, 4'hF, 32'h0000_000F);
    busWrite(32'h00, 4'hF, 32'h1);
    e_cyc = cyc;
    pushFrame(e_cyc, 1, 200, 32'hF00, 32'h00F);
    drain();

    // Frame counter, vblank, interrupt, and set-beats-clear on a frame-start cycle.
    $display("[TB] phase 2: frames and interrupt");
    resetDut();
    busWrite(32'h00, 4'hF, 32'h3);
    e_cyc = cyc;
    pushV(e_cyc + 320, 6, 32'd1);
    pushV(e_cyc + 400, 6, 32'd0);
    busRead(32'h00, 32'h3);
    waitUntil(e_cyc + 316);
    busRead(32'h0C, 32'h0003_0002);
    waitUntil(e_cyc + 393);
    busWrite(32'h10, 4'hF, 32'h1);
    waitUntil(e_cyc + 394);
    busRead(32'h0C, 32'h0001_0003);
    waitUntil(e_cyc + 395);
    busWrite(32'h10, 4'hF, 32'h1);
    waitUntil(e_cyc + 396);
    busRead(32'h0C, 32'h0000_0003);
    drain();

    // Byte enables, pattern bit, streamed source, then disable mid-frame and restart.
    $display("[TB] phase 3: streamed pixel and disable");
    resetDut();
    pix_rgb_i = 12'h0A5;
    busWrite(32'h04, 4'b0010, 32'hFFFF_FFFF);
    busWrite(32'h04, 4'b0001, 32'h1234_565A);
    busRead(32'h04, 32'h0000_0F5A);
    busWrite(32'h08, 4'hF, 32'h0000_000F);
    busWrite(32'h00, 4'h0, 32'h1);
    busRead(32'h00, 32'h0);
    busWrite(32'h00, 4'hF, 32'h8);
`ifdef VGA_TEST_PATTERN_EN
    busRead(32'h00, 32'h8);
`else
    busRead(32'h00, 32'h0);
`endif
    busWrite(32'h00, 4'hF, 32'h5);
    e_cyc = cyc;
    pushFrame(e_cyc, 1, 40, 32'h0A5, 32'h00F);
    pushV(e_cyc + 67, 0, 32'd0);
    pushV(e_cyc + 67, 1, 32'd0);
    pushV(e_cyc + 67, 2, 32'd0);
    pushV(e_cyc + 68, 3, 32'd1);
    pushV(e_cyc + 70, 0, 32'd0);
    waitUntil(e_cyc + 66);
    checkOutput("pos_before_disable", {16'(hcount_o), 16'(vcount_o)}, {16'd5, 16'd2});
    busWrite(32'h00, 4'hF, 32'h4);
    busRead(32'h0C, 32'h0001_0001);
    busWrite(32'h00, 4'hF, 32'h5);
    e_cyc = cyc;
    pushFrame(e_cyc, 1, 30, 32'h0A5, 32'h00F);
    waitUntil(e_cyc + 4);
    busRead(32'h0C, 32'h0001_0002);
    drain();

    // Asynchronous reset in the middle of a line, then an unmapped read.
    $display("[TB] phase 4: asynchronous reset");
    resetDut();
    pix_rgb_i = '0;
    busWrite(32'h04, 4'hF, 32'h0000_0F00);
    busWrite(32'h00, 4'hF, 32'h3);
    e_cyc = cyc;
    waitUntil(e_cyc + 20);
    busRead(32'h04, 32'h0000_0F00);
    waitUntil(e_cyc + 22);
    checkOutput("pre_reset_hsync", 32'(hsync_o), 32'd0);
    checkOutput("pre_reset_irq", 32'(frame_irq_o), 32'd1);
    checkOutput("pre_reset_rdata", device_rdata_o, 32'h0000_0F00);
    #2;
    rst_ni = 1'b0;
    #1;
    checkResetState("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    busRead(32'h14, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
